// File: rtl/ysyx_25060170_lsu.sv
// ysyx_25060170_lsu: LS-stage load/store unit with one outstanding memory access and LS/WB register.
// Optional misaligned-access exceptions are enabled by defining YSYX_25060170_LSU_MISALIGN_EN.
module ysyx_25060170_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ls_inst,
    input  logic [31:0] ls_pc,
    input  logic [31:0] ls_exu_res,
    input  logic [31:0] ls_store_data,
    input  logic [3:0]  ls_lsctl,
    input  logic [1:0]  ls_wbctl,
    input  logic        ls_rd_ena,
    input  logic [4:0]  ls_rd_addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err,
    output logic        ls_ready,
    output logic        ls_flush,
    output logic [3:0]  ls_exc_cause,
    output logic [31:0] ls_exc_tval,
    output logic [31:0] wb_inst,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_rd_data,
    output logic [1:0]  wb_wbctl,
    output logic        wb_rd_ena,
    output logic [4:0]  wb_rd_addr,
    output logic [4:0]  ls_rd_addr_forward,
    output logic [31:0] ls_rd_data_forward
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_q, state_d;
    logic [31:0] addr, load_data, rd_data, wb_inst_q, wb_pc_q, wb_rd_data_q;
    logic [15:0] rhalf;
    logic [7:0]  rbyte;
    logic [3:0]  cause;
    logic [1:0]  wb_wbctl_q;
    logic [4:0]  wb_rd_addr_q;
    logic        wb_rd_ena_q, lb, lh, lw, lbu, lhu, sb, sh, sw, is_load, is_store, misalign;
    logic        req_valid, ready, flush, wb_load;
    assign addr     = ls_exu_res;
    assign lb       = ls_lsctl == 4'b0001;
    assign lh       = ls_lsctl == 4'b0010;
    assign lw       = ls_lsctl == 4'b0011;
    assign lbu      = ls_lsctl == 4'b0100;
    assign lhu      = ls_lsctl == 4'b0101;
    assign sb       = ls_lsctl == 4'b1000;
    assign sh       = ls_lsctl == 4'b1001;
    assign sw       = ls_lsctl == 4'b1010;
    assign is_load  = lb | lh | lw | lbu | lhu;
    assign is_store = sb | sh | sw;
`ifdef YSYX_25060170_LSU_MISALIGN_EN
    assign misalign = ((lh | lhu | sh) & addr[0]) | ((lw | sw) & (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign rbyte     = mem_rsp_rdata[8*addr[1:0] +: 8];
    assign rhalf     = addr[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    assign load_data = lb  ? {{24{rbyte[7]}}, rbyte} :
                       lbu ? {24'b0, rbyte} :
                       lh  ? {{16{rhalf[15]}}, rhalf} :
                       lhu ? {16'b0, rhalf} : mem_rsp_rdata;
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        ready     = 1'b0;
        flush     = 1'b0;
        cause     = 4'd0;
        wb_load   = 1'b0;
        rd_data   = addr;
        if (state_q == IDLE) begin
            if (!(is_load | is_store)) begin
                wb_load = 1'b1;
            end else if (misalign) begin
                flush = 1'b1;
                cause = is_load ? 4'd4 : 4'd6;
            end else begin
                req_valid = 1'b1;
                ready     = 1'b1;
                state_d   = mem_req_ready ? WAIT : IDLE;
            end
        end else if (!mem_rsp_valid) begin
            ready = 1'b1;
        end else begin
            state_d = IDLE;
            if (mem_rsp_err) begin
                flush = 1'b1;
                cause = is_load ? 4'd5 : 4'd7;
            end else begin
                wb_load = 1'b1;
                rd_data = is_load ? load_data : addr;
            end
        end
    end
    // Handshake outputs are forced low while reset is held.
    assign mem_req_valid = rst & req_valid;
    assign ls_ready      = rst & ready & ~flush;
    assign ls_flush      = rst & flush;
    assign ls_exc_cause  = ls_flush ? cause : 4'd0;
    assign ls_exc_tval   = ls_flush ? addr : 32'd0;
    assign mem_req_wen   = is_store;
    assign mem_req_addr  = {addr[31:2], 2'b00};
    assign mem_req_wdata = sb ? {4{ls_store_data[7:0]}} : sh ? {2{ls_store_data[15:0]}} : sw ? ls_store_data : 32'd0;
    assign mem_req_wstrb = sb ? 4'b0001 << addr[1:0] : sh ? (addr[1] ? 4'b1100 : 4'b0011) : sw ? 4'b1111 : 4'b0000;
    assign ls_rd_addr_forward = ls_rd_ena ? ls_rd_addr : 5'd0;
    assign ls_rd_data_forward = !is_load ? addr : (state_q == WAIT && mem_rsp_valid) ? load_data : 32'd0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wb_inst_q    <= 32'd0;
            wb_pc_q      <= 32'd0;
            wb_rd_data_q <= 32'd0;
            wb_wbctl_q   <= 2'd0;
            wb_rd_ena_q  <= 1'b0;
            wb_rd_addr_q <= 5'd0;
        end else begin
            state_q      <= state_d;
            wb_inst_q    <= wb_load ? ls_inst : 32'd0;
            wb_pc_q      <= wb_load ? ls_pc : 32'd0;
            wb_rd_data_q <= wb_load ? rd_data : 32'd0;
            wb_wbctl_q   <= wb_load ? ls_wbctl : 2'd0;
            wb_rd_ena_q  <= wb_load & ls_rd_ena;
            wb_rd_addr_q <= wb_load ? ls_rd_addr : 5'd0;
        end
    end
    assign wb_inst    = wb_inst_q;
    assign wb_pc      = wb_pc_q;
    assign wb_rd_data = wb_rd_data_q;
    assign wb_wbctl   = wb_wbctl_q;
    assign wb_rd_ena  = wb_rd_ena_q;
    assign wb_rd_addr = wb_rd_addr_q;
endmodule

// File: doc/ysyx_25060170_lsu.md
# ysyx_25060170_lsu

Load/store unit for the LS stage of the ysyx_25060170 pipeline. It consumes the EX/LS pipeline register outputs, runs one memory transaction per load/store over a valid/ready request plus response channel, aligns and extends load data, and registers the result into the LS/WB boundary. It drives `ls_ready`, which holds the EX/LS register while an access is outstanding, and `ls_flush` on access exceptions. It also drives rd forwarding to the IDU.

## Interface
- No parameters; widths are fixed at 32-bit data and address, 5-bit register address.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-low reset.
- `ls_inst`, `ls_pc` in 32 each: instruction and PC from the EX/LS register.
- `ls_exu_res` in 32: effective address for memory operations; ALU result otherwise.
- `ls_store_data` in 32: rs2 value for stores.
- `ls_lsctl` in 4: access type. 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW. Any other value is treated as none.
- `ls_wbctl` in 2, `ls_rd_ena` in 1, `ls_rd_addr` in 5: writeback control, passed through.
- `mem_req_valid` out 1, `mem_req_ready` in 1: request handshake.
- `mem_req_wen` out 1: 1 for a store.
- `mem_req_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_req_wdata` out 32, `mem_req_wstrb` out 4: store data and byte strobes.
- `mem_rsp_valid` in 1, `mem_rsp_rdata` in 32, `mem_rsp_err` in 1: response. Exactly one response per accepted request, in order. Always accepted.
- `ls_ready` out 1: 1 holds the EX/LS register (stall).
- `ls_flush` out 1: one-cycle exception flush.
- `ls_exc_cause` out 4, `ls_exc_tval` out 32: valid while `ls_flush`=1; otherwise 0.
- `wb_inst`, `wb_pc` out 32 each; `wb_rd_data` out 32; `wb_wbctl` out 2; `wb_rd_ena` out 1; `wb_rd_addr` out 5: LS/WB register.
- `ls_rd_addr_forward` out 5, `ls_rd_data_forward` out 32: combinational forwarding.

## Operation
- FSM states: IDLE, WAIT.
- IDLE, lsctl none: `ls_ready`=0. On the next edge, the WB register loads the pass-through fields and `wb_rd_data`=`ls_exu_res`.
- IDLE, memory op, aligned:
  - `mem_req_valid`=1 and `ls_ready`=1.
  - On `mem_req_ready`=1 the FSM goes to WAIT. Otherwise it stays in IDLE with the request held stable, because the inputs are frozen by the stall.
- WAIT: `mem_req_valid`=0.
  - While `mem_rsp_valid`=0: `ls_ready`=1.
  - On `mem_rsp_valid`=1: `ls_ready`=0, and the FSM returns to IDLE on that edge.
  - If `mem_rsp_err`=0, the WB register loads. For loads, `wb_rd_data` is the extracted data; for stores it is `ls_exu_res`.
  - If `mem_rsp_err`=1: `ls_flush`=1, cause 5 (load) or 7 (store), tval = address, and the WB register loads a bubble.
- A bubble is all WB outputs 0.
- Load extraction:
  - Byte select is `addr[1:0]`; half select is `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store data and strobes:
  - SB: wdata `{4{d[7:0]}}`, wstrb `4'b0001<<addr[1:0]`.
  - SH: wdata `{2{d[15:0]}}`, wstrb `addr[1]?1100:0011`.
  - SW: wdata `d`, wstrb `1111`.
- Exception rule: whenever `ls_flush`=1, `ls_ready` is forced to 0. The EX/LS register gives stall priority over flush, so the flush would not take effect otherwise.
- Forwarding:
  - `ls_rd_addr_forward` = `ls_rd_ena ? ls_rd_addr : 0`.
  - Data is `ls_exu_res` for non-loads. For loads it is the extracted data during the response cycle and 0 at other times; the IDU stalls on load-use.

## Timing
- Reset (`rst`=0, asynchronous): FSM goes to IDLE and all WB outputs are 0. The combinational outputs `mem_req_valid`, `ls_ready` and `ls_flush` are 0 while reset is held.
- Latency:
  - Non-memory op: 1 cycle.
  - Load/store: at least 3 cycles (request accept, response, WB edge). With zero-wait memory, `ls_ready` is high for exactly 1 cycle.
- A response in the same cycle as the request is illegal; the bench never drives it.
- Reset asserted in WAIT abandons the transaction. The memory model is reset alongside.
- A WB bubble is inserted on the edge following any exception cycle.

## Configuration
- `YSYX_25060170_LSU_MISALIGN_EN` defined:
  - A LH/LHU/SH with `addr[0]`=1, or a LW/SW with `addr[1:0]`≠0, issues no request.
  - In IDLE: `ls_flush`=1, `ls_ready`=0, cause 4 (load) or 6 (store), tval = address, WB bubble.
- Undefined: no alignment check and no misalign exceptions.
  - Halfword ops ignore `addr[0]`; word ops ignore `addr[1:0]`.
  - `ls_flush` is raised only on `mem_rsp_err`.

## Test plan
- LB at 0x80000003, memory word 0x80FF1234, zero-wait → `wb_rd_data`=0xFFFFFF80. `ls_ready` high 1 cycle.
- SH at 0x80000002, data 0x0000ABCD, `mem_req_ready` low 3 cycles → request held stable 4 cycles with wdata 0xABCDABCD, wstrb 1100. WB loads after the response.
- LW at 0x80000001:
  - Macro on: `ls_flush`=1, cause 4, tval 0x80000001, no `mem_req_valid`, WB bubble.
  - Macro off: request to 0x80000000.
- SW response with `mem_rsp_err`=1 → `ls_flush`=1, `ls_ready`=0, cause 7, WB bubble.
- Back-to-back ADD, then LHU at addr+2 with word 0x8001_0000 → ADD reaches WB after 1 cycle. LHU `wb_rd_data`=0x00008001; forward data is valid only in the response cycle.
- Reset asserted mid-WAIT → FSM returns to IDLE, all outputs 0, and a new load after reset completes normally.
